// File: rtl/lsq_multi_cdb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_multi_cdb_pkg : op encodings, IO region and FSM codes for the LSQ      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package lsq_multi_cdb_pkg;

  typedef struct packed {
    logic       is_store;
    logic       uns;
    logic [1:0] size;
  } mem_op_t;

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;

  localparam logic [1:0] IO_HI = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lsq_multi_cdb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_multi_cdb_if : decoder / CDB / memory / result buses of the LSQ        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface lsq_multi_cdb_if #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32,
  parameter int CDB_N = 2
) ();

  logic                   rdy;
  logic                   flush;
  logic                   alloc_vld;
  logic [3:0]             alloc_op;
  logic                   alloc_rs1_rdy;
  logic                   alloc_rs2_rdy;
  logic [XLEN-1:0]        alloc_rs1;
  logic [XLEN-1:0]        alloc_rs2;
  logic [XLEN-1:0]        alloc_imm;
  logic [ROB_W-1:0]       alloc_rob;
  logic                   full;
  logic                   commit_st;
  logic [ROB_W-1:0]       rob_head;
  logic [CDB_N-1:0]       cdb_vld;
  logic [CDB_N*ROB_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_val;
  logic                   mem_req;
  logic [3:0]             mem_op;
  logic [XLEN-1:0]        mem_addr;
  logic [XLEN-1:0]        mem_wdata;
  logic                   mem_done;
  logic [XLEN-1:0]        mem_rdata;
  logic                   res_vld;
  logic [ROB_W-1:0]       res_tag;
  logic [XLEN-1:0]        res_val;

  modport master (
    output rdy, flush, alloc_vld, alloc_op, alloc_rs1_rdy, alloc_rs2_rdy,
           alloc_rs1, alloc_rs2, alloc_imm, alloc_rob, commit_st, rob_head,
           cdb_vld, cdb_tag, cdb_val, mem_done, mem_rdata,
    input  full, mem_req, mem_op, mem_addr, mem_wdata, res_vld, res_tag, res_val
  );

  modport slave (
    input  rdy, flush, alloc_vld, alloc_op, alloc_rs1_rdy, alloc_rs2_rdy,
           alloc_rs1, alloc_rs2, alloc_imm, alloc_rob, commit_st, rob_head,
           cdb_vld, cdb_tag, cdb_val, mem_done, mem_rdata,
    output full, mem_req, mem_op, mem_addr, mem_wdata, res_vld, res_tag, res_val
  );

endinterface
`default_nettype wire

// File: rtl/lsq_multi_cdb_operand_snoop.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_multi_cdb_operand_snoop : one operand slot, tag match against NB buses |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsq_multi_cdb_operand_snoop #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32,
  parameter int NB    = 3
) (
  input  logic                  i_rdy,
  input  logic [XLEN-1:0]       i_val,
  input  logic [NB-1:0]         i_bus_vld,
  input  logic [NB*ROB_W-1:0]   i_bus_tag,
  input  logic [NB*XLEN-1:0]    i_bus_val,
  output logic                  o_rdy,
  output logic [XLEN-1:0]       o_val
);

  // Scan from the highest bus down so the lowest matching channel wins.
  always_comb begin
    o_rdy = i_rdy;
    o_val = i_val;
    if (!i_rdy) begin
      for (int k = NB - 1; k >= 0; k--) begin
        if (i_bus_vld[k] && (i_bus_tag[k*ROB_W +: ROB_W] == i_val[ROB_W-1:0])) begin
          o_rdy = 1'b1;
          o_val = i_bus_val[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsq_multi_cdb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsq_multi_cdb : in-order load/store queue with multi-channel CDB snooping  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsq_multi_cdb
  import lsq_multi_cdb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ROB_W = 4,
  parameter int XLEN  = 32,
  parameter int CDB_N = 2
) (
  input  logic           clk,
  input  logic           rst,
  lsq_multi_cdb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = CDB_N + 1;

  logic [1:0]       r_state, w_state_nx;
  logic [AW-1:0]    r_head, r_tail, w_head_nx;
  logic [AW:0]      r_count, r_ccnt, w_ccnt_nx;
  logic [DEPTH-1:0] r_rs1_rdy, r_rs2_rdy;
  logic [XLEN-1:0]  r_rs1 [DEPTH];
  logic [XLEN-1:0]  r_rs2 [DEPTH];
  logic [XLEN-1:0]  r_imm [DEPTH];
  mem_op_t          r_op  [DEPTH];
  logic [ROB_W-1:0] r_rob [DEPTH];

  logic             r_mem_req;
  mem_op_t          r_mem_op;
  logic [XLEN-1:0]  r_mem_addr, r_mem_wdata;
  logic             r_res_vld;
  logic [ROB_W-1:0] r_res_tag;
  logic [XLEN-1:0]  r_res_val;

  logic [NB-1:0]       w_bus_vld;
  logic [NB*ROB_W-1:0] w_bus_tag;
  logic [NB*XLEN-1:0]  w_bus_val;

  logic             w_rs1_rdy_nx [DEPTH];
  logic             w_rs2_rdy_nx [DEPTH];
  logic [XLEN-1:0]  w_rs1_nx     [DEPTH];
  logic [XLEN-1:0]  w_rs2_nx     [DEPTH];
  logic             w_a1_rdy, w_a2_rdy;
  logic [XLEN-1:0]  w_a1_val, w_a2_val;

  mem_op_t          w_head_op;
  logic [XLEN-1:0]  w_head_addr;
  logic             w_head_vld, w_ops_rdy, w_is_io, w_rule, w_can_issue;
  logic             w_issue, w_pop, w_req_clr, w_st_pop, w_ld_done;
  logic             w_full, w_alloc;

  // The LSQ's own load result is the last (lowest-priority) snoop bus.
  assign w_bus_vld = {r_res_vld, bus.cdb_vld};
  assign w_bus_tag = {r_res_tag, bus.cdb_tag};
  assign w_bus_val = {r_res_val, bus.cdb_val};

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lsq_multi_cdb_operand_snoop #(.ROB_W(ROB_W), .XLEN(XLEN), .NB(NB)) u_rs1 (
      .i_rdy(r_rs1_rdy[i]), .i_val(r_rs1[i]),
      .i_bus_vld(w_bus_vld), .i_bus_tag(w_bus_tag), .i_bus_val(w_bus_val),
      .o_rdy(w_rs1_rdy_nx[i]), .o_val(w_rs1_nx[i])
    );
    lsq_multi_cdb_operand_snoop #(.ROB_W(ROB_W), .XLEN(XLEN), .NB(NB)) u_rs2 (
      .i_rdy(r_rs2_rdy[i]), .i_val(r_rs2[i]),
      .i_bus_vld(w_bus_vld), .i_bus_tag(w_bus_tag), .i_bus_val(w_bus_val),
      .o_rdy(w_rs2_rdy_nx[i]), .o_val(w_rs2_nx[i])
    );
  end

  lsq_multi_cdb_operand_snoop #(.ROB_W(ROB_W), .XLEN(XLEN), .NB(NB)) u_alloc_rs1 (
    .i_rdy(bus.alloc_rs1_rdy), .i_val(bus.alloc_rs1),
    .i_bus_vld(w_bus_vld), .i_bus_tag(w_bus_tag), .i_bus_val(w_bus_val),
    .o_rdy(w_a1_rdy), .o_val(w_a1_val)
  );
  lsq_multi_cdb_operand_snoop #(.ROB_W(ROB_W), .XLEN(XLEN), .NB(NB)) u_alloc_rs2 (
    .i_rdy(bus.alloc_rs2_rdy), .i_val(bus.alloc_rs2),
    .i_bus_vld(w_bus_vld), .i_bus_tag(w_bus_tag), .i_bus_val(w_bus_val),
    .o_rdy(w_a2_rdy), .o_val(w_a2_val)
  );

  function automatic logic [XLEN-1:0] f_extend(input mem_op_t op, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] v;
    case (op.size)
      SZ_B:    v = op.uns ? {{(XLEN-8){1'b0}}, d[7:0]}   : {{(XLEN-8){d[7]}}, d[7:0]};
      SZ_H:    v = op.uns ? {{(XLEN-16){1'b0}}, d[15:0]} : {{(XLEN-16){d[15]}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_head_op   = r_op[r_head];
  assign w_head_addr = r_rs1[r_head] + r_imm[r_head];
  assign w_head_vld  = (r_count != '0);
  assign w_ops_rdy   = r_rs1_rdy[r_head] & r_rs2_rdy[r_head];
  assign w_is_io     = (w_head_addr[17:16] == IO_HI);
  assign w_full      = (r_count == (AW+1)'(DEPTH));

  // Committed stores are contiguous from head, so "head index < ccnt" is ccnt != 0.
  always_comb begin
    if (w_head_op.is_store)
      w_rule = (r_ccnt != '0);
    else if (w_is_io)
      w_rule = (r_rob[r_head] == bus.rob_head) && !bus.flush;
    else
      w_rule = 1'b1;
  end

  assign w_can_issue = w_head_vld && w_ops_rdy && w_rule;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else if (bus.rdy)
      r_state <= w_state_nx;
  end

  // A load issued or in flight when flush hits belongs to a dropped entry: drain it.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_can_issue)
                 w_state_nx = (!w_head_op.is_store && bus.flush) ? S_DRAIN : S_BUSY;
      S_BUSY:  if (bus.mem_done)
                 w_state_nx = S_IDLE;
               else if (bus.flush && !r_mem_op.is_store)
                 w_state_nx = S_DRAIN;
      S_DRAIN: if (bus.mem_done)
                 w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue   = 1'b0;
    w_pop     = 1'b0;
    w_req_clr = 1'b0;
    case (r_state)
      S_IDLE:  w_issue = w_can_issue;
      S_BUSY:  begin
                 w_pop     = bus.mem_done;
                 w_req_clr = bus.mem_done;
               end
      S_DRAIN: w_req_clr = bus.mem_done;
      default: ;
    endcase
  end

  assign w_st_pop  = w_pop & r_mem_op.is_store;
  assign w_ld_done = w_pop & ~r_mem_op.is_store;

  // A slot freed by this cycle's pop may be refilled in the same cycle even when full.
  assign w_alloc   = bus.alloc_vld && (!w_full || w_pop) && !bus.flush;
  assign w_head_nx = r_head + AW'(w_pop);
  assign w_ccnt_nx = r_ccnt + (AW+1)'(bus.commit_st) - (AW+1)'(w_st_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ccnt      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_op    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_res_vld   <= 1'b0;
      r_res_tag   <= '0;
      r_res_val   <= '0;
    end else if (bus.rdy) begin
      r_head <= w_head_nx;
      r_ccnt <= w_ccnt_nx;
      if (bus.flush) begin
        r_tail  <= w_head_nx + w_ccnt_nx[AW-1:0];
        r_count <= w_ccnt_nx;
      end else begin
        r_tail  <= r_tail + AW'(w_alloc);
        r_count <= r_count + (AW+1)'(w_alloc) - (AW+1)'(w_pop);
      end
      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_op    <= w_head_op;
        r_mem_addr  <= w_head_addr;
        r_mem_wdata <= r_rs2[r_head];
      end else if (w_req_clr) begin
        r_mem_req   <= 1'b0;
      end
      r_res_vld <= w_ld_done && !bus.flush;
      if (w_ld_done) begin
        r_res_tag <= r_rob[r_head];
        r_res_val <= f_extend(r_mem_op, bus.mem_rdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1_rdy <= '0;
      r_rs2_rdy <= '0;
    end else if (bus.rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rs1_rdy[i] <= w_rs1_rdy_nx[i];
        r_rs2_rdy[i] <= w_rs2_rdy_nx[i];
        r_rs1[i]     <= w_rs1_nx[i];
        r_rs2[i]     <= w_rs2_nx[i];
      end
      if (w_alloc) begin
        r_op[r_tail]      <= mem_op_t'(bus.alloc_op);
        r_rob[r_tail]     <= bus.alloc_rob;
        r_imm[r_tail]     <= bus.alloc_imm;
        r_rs1_rdy[r_tail] <= w_a1_rdy;
        r_rs2_rdy[r_tail] <= w_a2_rdy;
        r_rs1[r_tail]     <= w_a1_val;
        r_rs2[r_tail]     <= w_a2_val;
      end
    end
  end

  assign bus.full      = w_full;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_op    = r_mem_op;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.res_vld   = r_res_vld;
  assign bus.res_tag   = r_res_tag;
  assign bus.res_val   = r_res_val;

endmodule
`default_nettype wire

// File: tb/tb_lsq_multi_cdb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsq_multi_cdb : directed self-checking bench for lsq_multi_cdb          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_lsq_multi_cdb;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  lsq_multi_cdb_if #(.ROB_W(4), .XLEN(32), .CDB_N(2)) bus ();

  lsq_multi_cdb #(.DEPTH(16), .ROB_W(4), .XLEN(32), .CDB_N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [3:0] op, input logic r1r, input logic [31:0] r1,
                       input logic r2r, input logic [31:0] r2, input logic [31:0] imm,
                       input logic [3:0] rob);
    bus.alloc_vld     = 1'b1;
    bus.alloc_op      = op;
    bus.alloc_rs1_rdy = r1r;
    bus.alloc_rs1     = r1;
    bus.alloc_rs2_rdy = r2r;
    bus.alloc_rs2     = r2;
    bus.alloc_imm     = imm;
    bus.alloc_rob     = rob;
    tick();
    bus.alloc_vld     = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, then complete it with rdata.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata);
    int n = 0;
    while (!bus.mem_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
    chk({tag, "_addr"}, bus.mem_addr, addr);
    chk({tag, "_wdata"}, bus.mem_wdata, wdata);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_done  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.rdy = 1'b1;           bus.flush = 1'b0;       bus.alloc_vld = 1'b0;
    bus.alloc_op = '0;        bus.alloc_rs1_rdy = 1'b0; bus.alloc_rs2_rdy = 1'b0;
    bus.alloc_rs1 = '0;       bus.alloc_rs2 = '0;     bus.alloc_imm = '0;
    bus.alloc_rob = '0;       bus.commit_st = 1'b0;   bus.rob_head = '0;
    bus.cdb_vld = '0;         bus.cdb_tag = '0;       bus.cdb_val = '0;
    bus.mem_done = 1'b0;      bus.mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_full",    {31'd0, bus.full},    32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_res_vld", {31'd0, bus.res_vld}, 32'd0);
    chk("rst_addr",    bus.mem_addr,         32'd0);
    chk("rst_res_val", bus.res_val,          32'd0);

    // LW: issue one cycle after the entry lands, result one cycle after mem_done
    alloc(4'b0010, 1, 32'h100, 1, 32'h0, 32'h4, 4'd1);
    chk("lw_no_req_yet", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("lw_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("lw_op",   {28'd0, bus.mem_op},  32'h2);
    serve("lw", 32'h104, 32'h0, 32'h80);
    chk("lw_res_vld", {31'd0, bus.res_vld}, 32'd1);
    chk("lw_res_val", bus.res_val,          32'h80);
    chk("lw_res_tag", {28'd0, bus.res_tag}, 32'd1);
    chk("lw_req_drop", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("lw_res_pulse", {31'd0, bus.res_vld}, 32'd0);

    // LB with a rdy-low stall while BUSY
    alloc(4'b0000, 1, 32'h200, 1, 32'h0, 32'h0, 4'd2);
    tick();
    bus.rdy = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_rdata = 32'h0000_00F0;
    tick();
    bus.rdy = 1'b1;
    bus.mem_done = 1'b0;
    chk("rdy_hold_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rdy_hold_res", {31'd0, bus.res_vld}, 32'd0);
    serve("lb", 32'h200, 32'h0, 32'h0000_00F0);
    chk("lb_sext", bus.res_val, 32'hFFFF_FFF0);

    alloc(4'b0100, 1, 32'h204, 1, 32'h0, 32'h0, 4'd3);
    serve("lbu", 32'h204, 32'h0, 32'h0000_00F0);
    chk("lbu_zext", bus.res_val, 32'h0000_00F0);

    alloc(4'b0001, 1, 32'h208, 1, 32'h0, 32'h0, 4'd4);
    serve("lh", 32'h208, 32'h0, 32'h0000_8001);
    chk("lh_sext", bus.res_val, 32'hFFFF_8001);

    // SW waits for commit_st
    alloc(4'b1010, 1, 32'h40, 1, 32'hDEAD_BEEF, 32'h0, 4'd6);
    repeat (5) tick();
    chk("sw_wait_commit", {31'd0, bus.mem_req}, 32'd0);
    bus.commit_st = 1'b1;
    tick();
    bus.commit_st = 1'b0;
    chk("sw_commit_edge", {31'd0, bus.mem_req}, 32'd0);
    tick();
    chk("sw_req", {31'd0, bus.mem_req}, 32'd1);
    serve("sw", 32'h40, 32'hDEAD_BEEF, 32'h0);
    chk("sw_no_bcast", {31'd0, bus.res_vld}, 32'd0);

    // Alloc bypass from cdb channel 1, then duplicate tags (channel 0 wins)
    bus.cdb_vld = 2'b10;
    bus.cdb_tag = {4'd3, 4'd9};
    bus.cdb_val = {32'h200, 32'h999};
    alloc(4'b0010, 0, 32'd3, 1, 32'h0, 32'h10, 4'd7);
    bus.cdb_vld = 2'b00;
    serve("byp", 32'h210, 32'h0, 32'h1);
    bus.cdb_vld = 2'b11;
    bus.cdb_tag = {4'd5, 4'd5};
    bus.cdb_val = {32'h400, 32'h300};
    alloc(4'b0010, 0, 32'd5, 1, 32'h0, 32'h0, 4'd7);
    bus.cdb_vld = 2'b00;
    serve("byp_prio", 32'h300, 32'h0, 32'h1);

    // Wakeup through the LSQ's own result broadcast
    alloc(4'b0010, 1, 32'h100, 1, 32'h0, 32'h0, 4'd8);
    alloc(4'b0010, 0, 32'd8, 1, 32'h0, 32'h8, 4'd9);
    serve("wk_a", 32'h100, 32'h0, 32'h600);
    serve("wk_b", 32'h608, 32'h0, 32'h5);
    chk("wk_b_tag", {28'd0, bus.res_tag}, 32'd9);

    // Fill, full, ignored extra alloc, pop+alloc keeps full, flush drains
    for (int i = 0; i < 16; i++)
      alloc(4'b1010, 1, 32'h1000 + 32'(i) * 4, 1, 32'(i), 32'h0, 4'(i));
    chk("full_set", {31'd0, bus.full}, 32'd1);
    alloc(4'b1010, 1, 32'h2000, 1, 32'h0, 32'h0, 4'd15);
    chk("full_extra", {31'd0, bus.full}, 32'd1);
    bus.commit_st = 1'b1;
    tick();
    bus.commit_st = 1'b0;
    tick();
    chk("full_pop_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("full_pop_addr", bus.mem_addr, 32'h1000);
    bus.mem_done  = 1'b1;
    bus.alloc_vld = 1'b1;
    tick();
    bus.mem_done  = 1'b0;
    bus.alloc_vld = 1'b0;
    chk("full_pop_alloc", {31'd0, bus.full}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("full_flush", {31'd0, bus.full}, 32'd0);
    tick();
    tick();
    chk("full_flush_idle", {31'd0, bus.mem_req}, 32'd0);

    // Load in BUSY + flush -> DRAIN; stores allocated afterwards issue in order
    alloc(4'b0010, 1, 32'h30, 1, 32'h0, 32'h0, 4'd3);
    alloc(4'b0010, 1, 32'h34, 1, 32'h0, 32'h0, 4'd4);
    chk("dr_busy_addr", bus.mem_addr, 32'h30);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    alloc(4'b1010, 1, 32'h10, 1, 32'h11, 32'h0, 4'd5);
    alloc(4'b1010, 1, 32'h20, 1, 32'h22, 32'h0, 4'd6);
    bus.commit_st = 1'b1;
    tick();
    tick();
    bus.commit_st = 1'b0;
    tick();
    chk("dr_hold_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("dr_hold_addr", bus.mem_addr, 32'h30);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'h1234;
    tick();
    bus.mem_done  = 1'b0;
    chk("dr_no_res", {31'd0, bus.res_vld}, 32'd0);
    chk("dr_req_off", {31'd0, bus.mem_req}, 32'd0);
    serve("dr_st1", 32'h10, 32'h11, 32'h0);
    serve("dr_st2", 32'h20, 32'h22, 32'h0);
    repeat (3) tick();
    chk("dr_loads_gone", {31'd0, bus.mem_req}, 32'd0);

    // Committed store with pending data survives flush; younger load dropped
    alloc(4'b1010, 1, 32'h50, 0, 32'd6, 32'h0, 4'd10);
    bus.commit_st = 1'b1;
    tick();
    bus.commit_st = 1'b0;
    alloc(4'b0010, 1, 32'h60, 1, 32'h0, 32'h0, 4'd11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("kf_no_req", {31'd0, bus.mem_req}, 32'd0);
    bus.cdb_vld = 2'b01;
    bus.cdb_tag = {4'd0, 4'd6};
    bus.cdb_val = {32'h0, 32'hABCD};
    tick();
    bus.cdb_vld = 2'b00;
    serve("kf_st", 32'h50, 32'hABCD, 32'h0);
    repeat (3) tick();
    chk("kf_ld_gone", {31'd0, bus.mem_req}, 32'd0);

    // mem_done coinciding with flush suppresses the broadcast
    alloc(4'b0101, 1, 32'h80, 1, 32'h0, 32'h0, 4'd12);
    tick();
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'hFFFF;
    bus.flush     = 1'b1;
    tick();
    bus.mem_done  = 1'b0;
    bus.flush     = 1'b0;
    chk("fd_no_res", {31'd0, bus.res_vld}, 32'd0);
    chk("fd_req_off", {31'd0, bus.mem_req}, 32'd0);

    // IO load waits for rob_head
    bus.rob_head = 4'd4;
    alloc(4'b0010, 1, 32'h30000, 1, 32'h0, 32'h0, 4'd5);
    repeat (4) tick();
    chk("io_blocked", {31'd0, bus.mem_req}, 32'd0);
    bus.rob_head = 4'd5;
    tick();
    chk("io_req", {31'd0, bus.mem_req}, 32'd1);
    serve("io", 32'h30000, 32'h0, 32'h77);
    chk("io_res_val", bus.res_val, 32'h77);
    chk("io_res_tag", {28'd0, bus.res_tag}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
